exp_sprite_ctrl: RTL and testbench
==================================

Name: exp_sprite_ctrl

Overview:
- Drives the 20x20 explosion sprite ROM for one on-screen explosion.
- Latches a trigger position and runs a frame-based lifetime with an end-of-life blink.
- Converts the VGA raster position (DrawX/DrawY) into a ROM address, reads back the 4-bit palette index, and hands a pixel-valid flag and index to the colour mapper.
- Sits between the game/collision logic (upstream) and the sprite ROM plus colour mapper (downstream).

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 20, sprite height in pixels
- LIFE_FRAMES, 30, frames an explosion stays active (1..255)
- BLINK_FRAMES, 8, final frames during which the sprite blinks (must be < LIFE_FRAMES)

Ports:
- Clk  in  1  system/pixel clock
- Reset_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- trigger  in  1  one-cycle request to start an explosion
- trig_x  in  10  top-left X of new explosion (0..639)
- trig_y  in  10  top-left Y of new explosion (0..479)
- DrawX  in  10  current raster X
- DrawY  in  10  current raster Y
- rom_addr  out  9  address to sprite ROM (0..399)
- rom_data  in  4  palette index from ROM; combinational, same cycle as rom_addr
- exp_on  out  1  explosion pixel visible (index non-zero)
- exp_idx  out  4  palette index for colour mapper
- busy  out  1  explosion pending or active
- done  out  1  one-cycle pulse when an explosion expires

Behaviour:
- Reset (async, Reset_n=0) clears outputs and state:
  - rom_addr=0, exp_on=0, exp_idx=0, busy=0, done=0.
  - state=IDLE, pending=0, pos_x=pos_y=0, frame_cnt=0.
- States: IDLE, ACTIVE. The `pending` flag is separate from the state.
- trigger=1:
  - sets pending and captures trig_x/trig_y into staging registers.
  - A later trigger before the next frame_tick overwrites the staging registers; the last one wins.
- frame_tick with pending=1 (pending set before this cycle):
  - staging loads pos_x/pos_y, frame_cnt=0, state=ACTIVE, pending=0.
  - This applies in either state, so a retrigger restarts the animation at the new position.
  - A trigger in the same cycle as frame_tick is not consumed by that tick. It stays pending for the next tick.
- frame_tick in ACTIVE with pending=0:
  - if frame_cnt==LIFE_FRAMES-1: state=IDLE, done=1 for one cycle.
  - else frame_cnt+1.
  - A pending restart on the same tick suppresses done.
- Position only changes on frame_tick, so there is no tearing mid-frame.
- busy = pending OR (state==ACTIVE), combinational from registers.
- Visibility: vis = ACTIVE AND NOT (frame_cnt >= LIFE_FRAMES-BLINK_FRAMES AND frame_cnt[0]==1).
- Stage 1 (registered, 1 cycle after DrawX/DrawY):
  - dx = {1'b0,DrawX} - {1'b0,pos_x}, dy likewise; both 11-bit.
  - hit = dx[10]==0 AND dx<SPR_W AND dy[10]==0 AND dy<SPR_H AND vis.
  - rom_addr = dy*SPR_W + dx (9 bits) when hit, else 0.
  - hit_s1 = hit.
- Stage 2 (registered, 2 cycles after DrawX/DrawY):
  - exp_idx = hit_s1 ? rom_data : 0.
  - exp_on = hit_s1 AND (rom_data != 0). Index 0 is transparent.
- Edge clipping: pos_x>620 or pos_y>460 clips naturally; raster never reaches off-screen pixels, and no wrap to the left edge is allowed.
- Address range: DrawX/DrawY wrap at line/frame end is handled by the 11-bit borrow test; rom_addr never exceeds 399.

Test Plan:
- Reset then idle frames:
  - Reset_n low 3 cycles, release, run 2 frame_ticks with no trigger.
  - Required: busy=0, exp_on=0, rom_addr=0 throughout.
- Basic draw:
  - trigger with trig_x=100, trig_y=50, then frame_tick; sweep DrawX=99..121 at DrawY=59.
  - Required: rom_addr = 9*20+(DrawX-100) one cycle later for DrawX 100..119, else 0.
  - Required: exp_on/exp_idx match the ROM row 2 cycles later; exp_on=0 where the index is 0.
- Lifetime and blink:
  - Trigger, then count 30 frame_ticks.
  - Required: vis=1 for frame_cnt 0..21; frames 22..29 visible only on even frame_cnt.
  - Required: done pulses exactly once on the 30th tick after start, then busy=0.
- Trigger/tick collision:
  - Assert trigger in the same cycle as frame_tick.
  - Required: state remains IDLE, busy=1 (pending); ACTIVE begins on the following frame_tick.
- Retrigger while active:
  - At frame_cnt=10, trigger at (300,200), then frame_tick.
  - Required: frame_cnt=0, pos=(300,200), no done pulse, old position never drawn in the new frame.
- Edge clip and async reset:
  - Explosion at (630,470): DrawX 0..9 on rows 470..479 gives exp_on=0; DrawX 630..639 draws normally.
  - Assert Reset_n mid-line: all outputs 0 immediately, without waiting for a Clk edge.

Source files
------------

// File: rtl/exp_sprite_ctrl.sv
// Explosion sprite controller: latches a trigger position, runs a frame-based
// lifetime with an end-of-life blink, and turns the raster position into ROM reads.
module exp_sprite_ctrl #(
    parameter int SPR_W        = 20,
    parameter int SPR_H        = 20,
    parameter int LIFE_FRAMES  = 30,
    parameter int BLINK_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       trigger,
    input  logic [9:0] trig_x,
    input  logic [9:0] trig_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [8:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic       exp_on,
    output logic [3:0] exp_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0]  LAST_FRAME  = 8'(LIFE_FRAMES - 1);
    localparam logic [7:0]  BLINK_START = 8'(LIFE_FRAMES - BLINK_FRAMES);
    localparam logic [10:0] SPR_W_L     = 11'(SPR_W);
    localparam logic [10:0] SPR_H_L     = 11'(SPR_H);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t     state, state_nxt;
    logic       pending, pending_nxt;
    logic [9:0] stg_x, stg_y;
    logic [9:0] pos_x, pos_y, pos_x_nxt, pos_y_nxt;
    logic [7:0] frame_cnt, frame_cnt_nxt;
    logic       done_nxt;

    logic        vis;
    logic [10:0] dx, dy;
    logic        hit;
    logic [8:0]  addr_calc;
    logic        hit_s1;

    // Staging registers: the last trigger before a frame tick wins.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stg_x <= '0;
            stg_y <= '0;
        end else if (trigger) begin
            stg_x <= trig_x;
            stg_y <= trig_y;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            pos_x     <= '0;
            pos_y     <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            pos_x     <= pos_x_nxt;
            pos_y     <= pos_y_nxt;
            frame_cnt <= frame_cnt_nxt;
            done      <= done_nxt;
        end
    end

    // A pending restart takes priority over ageing, so it also suppresses done.
    // A trigger coinciding with the tick only re-arms pending for the next tick.
    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        pos_x_nxt     = pos_x;
        pos_y_nxt     = pos_y;
        frame_cnt_nxt = frame_cnt;
        done_nxt      = 1'b0;

        if (frame_tick && pending) begin
            pos_x_nxt     = stg_x;
            pos_y_nxt     = stg_y;
            frame_cnt_nxt = '0;
            state_nxt     = ACTIVE;
            pending_nxt   = 1'b0;
        end else if (frame_tick && (state == ACTIVE)) begin
            if (frame_cnt == LAST_FRAME) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                frame_cnt_nxt = frame_cnt + 8'd1;
            end
        end

        if (trigger) begin
            pending_nxt = 1'b1;
        end
    end

    assign busy = pending || (state == ACTIVE);

    assign vis = (state == ACTIVE) && !((frame_cnt >= BLINK_START) && frame_cnt[0]);

    // Bit 10 acts as the borrow: a raster left of / above the sprite never wraps in.
    assign dx  = {1'b0, DrawX} - {1'b0, pos_x};
    assign dy  = {1'b0, DrawY} - {1'b0, pos_y};
    assign hit = !dx[10] && (dx < SPR_W_L) && !dy[10] && (dy < SPR_H_L) && vis;
    assign addr_calc = 9'(dy * SPR_W_L + dx);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            hit_s1   <= 1'b0;
        end else begin
            rom_addr <= hit ? addr_calc : 9'd0;
            hit_s1   <= hit;
        end
    end

    // Palette index 0 is transparent.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            exp_idx <= '0;
            exp_on  <= 1'b0;
        end else begin
            exp_idx <= hit_s1 ? rom_data : 4'd0;
            exp_on  <= hit_s1 && (rom_data != 4'd0);
        end
    end

endmodule

// File: tb/tb_exp_sprite_ctrl.sv
// Directed bench for exp_sprite_ctrl with a small combinational ROM model.
module tb_exp_sprite_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick;
    logic       trigger;
    logic [9:0] trig_x, trig_y;
    logic [9:0] DrawX, DrawY;
    logic [8:0] rom_addr;
    logic [3:0] rom_data;
    logic       exp_on;
    logic [3:0] exp_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    exp_sprite_ctrl dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .trigger    (trigger),
        .trig_x     (trig_x),
        .trig_y     (trig_y),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .exp_on     (exp_on),
        .exp_idx    (exp_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM stand-in: some transparent entries, others a mix of address bits.
    function automatic logic [3:0] rom_fn(input logic [8:0] a);
        if (a[2:0] == 3'd0) return 4'd0;
        return a[3:0] ^ a[7:4];
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_trigger(input logic [9:0] x, input logic [9:0] y);
        trigger = 1'b1;
        trig_x  = x;
        trig_y  = y;
        step();
        trigger = 1'b0;
    endtask

    task automatic pulse_tick(output logic d);
        frame_tick = 1'b1;
        step();
        d = done;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        logic d;
        Reset_n = 1'b0;
        frame_tick = 1'b0; trigger = 1'b0; trig_x = '0; trig_y = '0;
        DrawX = 10'd5; DrawY = 10'd5;
        repeat (3) step();
        checks++; if (rom_addr !== 9'd0) begin errors++; $display("[TB] FAIL reset_rom_addr got %0d want 0", rom_addr); end
        checks++; if (exp_on !== 1'b0) begin errors++; $display("[TB] FAIL reset_exp_on got %b want 0", exp_on); end
        checks++; if (exp_idx !== 4'd0) begin errors++; $display("[TB] FAIL reset_exp_idx got %0d want 0", exp_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        Reset_n = 1'b1;
        step();
        for (int t = 0; t < 2; t++) begin
            pulse_tick(d);
            checks++; if (d !== 1'b0) begin errors++; $display("[TB] FAIL idle_done got %b want 0", d); end
            for (int c = 0; c < 3; c++) begin
                DrawX = 10'(c); DrawY = 10'(c);
                step();
                checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
                checks++; if (exp_on !== 1'b0) begin errors++; $display("[TB] FAIL idle_exp_on got %b want 0", exp_on); end
                checks++; if (rom_addr !== 9'd0) begin errors++; $display("[TB] FAIL idle_rom_addr got %0d want 0", rom_addr); end
            end
        end
        DrawX = '0; DrawY = '0;
    endtask

    task automatic test_basic_draw();
        logic d;
        logic prev_hit, cur_hit;
        logic [8:0] prev_addr, cur_addr;
        logic [3:0] want_idx;
        do_trigger(10'd100, 10'd50);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL draw_pending_busy got %b want 1", busy); end
        pulse_tick(d);
        prev_hit = 1'b0; prev_addr = '0;
        DrawY = 10'd59;
        for (int x = 99; x <= 122; x++) begin
            DrawX = 10'(x);
            step();
            cur_hit  = (x >= 100) && (x <= 119);
            cur_addr = cur_hit ? 9'(180 + x - 100) : 9'd0;
            want_idx = prev_hit ? rom_fn(prev_addr) : 4'd0;
            checks++; if (rom_addr !== cur_addr) begin errors++; $display("[TB] FAIL draw_rom_addr x=%0d got %0d want %0d", x, rom_addr, cur_addr); end
            checks++; if (exp_idx !== want_idx) begin errors++; $display("[TB] FAIL draw_exp_idx x=%0d got %0d want %0d", x, exp_idx, want_idx); end
            checks++; if (exp_on !== (want_idx != 4'd0)) begin errors++; $display("[TB] FAIL draw_exp_on x=%0d got %b want %b", x, exp_on, want_idx != 4'd0); end
            prev_hit = cur_hit; prev_addr = cur_addr;
        end
        DrawX = '0; DrawY = '0;
    endtask

    task automatic test_lifetime();
        logic d;
        logic want_vis;
        do_trigger(10'd100, 10'd50);
        pulse_tick(d);
        for (int n = 0; n < 30; n++) begin
            DrawX = 10'd105; DrawY = 10'd55;
            step();
            want_vis = (n < 22) || (n % 2 == 0);
            checks++; if (rom_addr !== (want_vis ? 9'd105 : 9'd0)) begin errors++; $display("[TB] FAIL life_vis fc=%0d got addr %0d want vis %b", n, rom_addr, want_vis); end
            DrawX = '0; DrawY = '0;
            pulse_tick(d);
            checks++; if (d !== (n == 29)) begin errors++; $display("[TB] FAIL life_done tick=%0d got %b want %b", n + 1, d, n == 29); end
        end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL life_done_pulse got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL life_busy_end got %b want 0", busy); end
    endtask

    task automatic test_tick_collision();
        logic d;
        trigger = 1'b1; trig_x = 10'd200; trig_y = 10'd100; frame_tick = 1'b1;
        step();
        trigger = 1'b0; frame_tick = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL coll_busy got %b want 1", busy); end
        DrawX = 10'd203; DrawY = 10'd101;
        step();
        checks++; if (rom_addr !== 9'd0) begin errors++; $display("[TB] FAIL coll_still_idle got %0d want 0", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL coll_pending got %b want 1", busy); end
        pulse_tick(d);
        checks++; if (d !== 1'b0) begin errors++; $display("[TB] FAIL coll_done got %b want 0", d); end
        step();
        checks++; if (rom_addr !== 9'd23) begin errors++; $display("[TB] FAIL coll_active_addr got %0d want 23", rom_addr); end
    endtask

    task automatic test_retrigger();
        logic d;
        for (int n = 0; n < 10; n++) begin
            pulse_tick(d);
            checks++; if (d !== 1'b0) begin errors++; $display("[TB] FAIL retrig_age_done got %b want 0", d); end
        end
        do_trigger(10'd300, 10'd200);
        checks++; if (rom_addr !== 9'd23) begin errors++; $display("[TB] FAIL retrig_old_before got %0d want 23", rom_addr); end
        pulse_tick(d);
        checks++; if (d !== 1'b0) begin errors++; $display("[TB] FAIL retrig_done got %b want 0", d); end
        step();
        checks++; if (rom_addr !== 9'd0) begin errors++; $display("[TB] FAIL retrig_old_pos got %0d want 0", rom_addr); end
        DrawX = 10'd305; DrawY = 10'd202;
        step();
        checks++; if (rom_addr !== 9'd45) begin errors++; $display("[TB] FAIL retrig_new_pos got %0d want 45", rom_addr); end
        DrawX = '0; DrawY = '0;
        for (int n = 0; n < 30; n++) begin
            pulse_tick(d);
            checks++; if (d !== (n == 29)) begin errors++; $display("[TB] FAIL retrig_life tick=%0d got %b want %b", n + 1, d, n == 29); end
        end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL retrig_busy_end got %b want 0", busy); end
    endtask

    task automatic test_edge_clip();
        logic d;
        logic prev_hit, cur_hit;
        logic [8:0] prev_addr, cur_addr;
        logic [3:0] want_idx;
        do_trigger(10'd630, 10'd470);
        pulse_tick(d);
        for (int y = 470; y < 480; y++) begin
            for (int x = 0; x < 10; x++) begin
                DrawY = 10'(y); DrawX = 10'(x);
                step();
                checks++; if (rom_addr !== 9'd0) begin errors++; $display("[TB] FAIL clip_wrap_addr (%0d,%0d) got %0d want 0", x, y, rom_addr); end
                checks++; if (exp_on !== 1'b0) begin errors++; $display("[TB] FAIL clip_wrap_on (%0d,%0d) got %b want 0", x, y, exp_on); end
            end
        end
        DrawY = 10'd475; DrawX = 10'd0;
        step();
        prev_hit = 1'b0; prev_addr = '0;
        for (int i = 0; i <= 10; i++) begin
            DrawX = (i < 10) ? 10'(630 + i) : 10'd0;
            step();
            cur_hit  = (i < 10);
            cur_addr = cur_hit ? 9'(100 + i) : 9'd0;
            want_idx = prev_hit ? rom_fn(prev_addr) : 4'd0;
            checks++; if (rom_addr !== cur_addr) begin errors++; $display("[TB] FAIL clip_edge_addr i=%0d got %0d want %0d", i, rom_addr, cur_addr); end
            checks++; if (exp_idx !== want_idx) begin errors++; $display("[TB] FAIL clip_edge_idx i=%0d got %0d want %0d", i, exp_idx, want_idx); end
            prev_hit = cur_hit; prev_addr = cur_addr;
        end
    endtask

    task automatic test_async_reset();
        DrawX = 10'd635; DrawY = 10'd475;
        step();
        step();
        checks++; if (rom_addr !== 9'd105) begin errors++; $display("[TB] FAIL areset_pre_addr got %0d want 105", rom_addr); end
        checks++; if (exp_idx !== rom_fn(9'd105)) begin errors++; $display("[TB] FAIL areset_pre_idx got %0d want %0d", exp_idx, rom_fn(9'd105)); end
        checks++; if (exp_on !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_on got %b want 1", exp_on); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_busy got %b want 1", busy); end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (rom_addr !== 9'd0) begin errors++; $display("[TB] FAIL areset_addr got %0d want 0", rom_addr); end
        checks++; if (exp_on !== 1'b0) begin errors++; $display("[TB] FAIL areset_on got %b want 0", exp_on); end
        checks++; if (exp_idx !== 4'd0) begin errors++; $display("[TB] FAIL areset_idx got %0d want 0", exp_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL areset_done got %b want 0", done); end
        step();
        Reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_draw();
        test_lifetime();
        test_tick_collision();
        test_retrigger();
        test_edge_clip();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
